// File: rtl/pc_sequencer.sv
// Program-counter sequencer: 4-phase instruction cycle, PC commit on
// the edge leaving phase 3, with sequential/branch/jump next-PC select.
module pc_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [15:0]         branch_offset,
    input  logic                jump,
    input  logic [25:0]         jump_target,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [1:0]          phase,
    output logic                pc_clk_out,
    output logic                pc_we
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    phase_t              r_phase;
    phase_t              w_phase_nxt;
    logic                w_pc_we;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_br_off;
    logic [PC_WIDTH-1:0] w_br_pc;
    logic [PC_WIDTH-1:0] w_jmp_pc;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH0;
            r_pc    <= RESET_PC;
        end else begin
            r_phase <= w_phase_nxt;
            if (w_pc_we) begin
                r_pc <= w_pc_nxt;
            end
        end
    end

    // Stall only freezes phase 3; earlier phases run regardless.
    always_comb begin
        w_phase_nxt = r_phase;
        w_pc_we     = 1'b0;
        case (r_phase)
            PH0: w_phase_nxt = PH1;
            PH1: w_phase_nxt = PH2;
            PH2: w_phase_nxt = PH3;
            PH3: begin
                if (!stall) begin
                    w_phase_nxt = PH0;
                    w_pc_we     = 1'b1;
                end
            end
            default: w_phase_nxt = PH0;
        endcase
    end

    assign w_pc_plus4 = r_pc + PC_WIDTH'(4);

    assign w_br_off = {{(PC_WIDTH-18){branch_offset[15]}},
                       branch_offset, 2'b00};

    assign w_br_pc  = w_pc_plus4 + w_br_off;

    // Jump keeps the upper region bits of the sequential PC.
    assign w_jmp_pc = {w_pc_plus4[PC_WIDTH-1:28], jump_target, 2'b00};

    always_comb begin
        w_pc_nxt = w_pc_plus4;
        if (jump) begin
            w_pc_nxt = w_jmp_pc;
        end else if (branch_taken) begin
            w_pc_nxt = w_br_pc;
        end
    end

    assign pc_out     = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign phase      = r_phase;
    assign pc_clk_out = ~r_phase[1];
    assign pc_we      = w_pc_we;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle vector table plus
// hand-written reset, priority and stall/reset corner sequences.
module tb_pc_sequencer;

    logic        clk_in;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [1:0]  phase;
    logic        pc_clk_out;
    logic        pc_we;
    logic [31:0] hi_pc_out;
    logic [31:0] hi_pc_plus4;
    logic [1:0]  hi_phase;
    logic        hi_pc_clk_out;
    logic        hi_pc_we;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] off;
        logic        jmp;
        logic [25:0] tgt;
        logic [1:0]  ph;
        logic [31:0] pc;
        logic        ce;
        logic        we;
    } vec_t;

    vec_t vq[$];

    pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .phase        (phase),
        .pc_clk_out   (pc_clk_out),
        .pc_we        (pc_we)
    );

    pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h4000_0000)) u_hi (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_out       (hi_pc_out),
        .pc_plus4     (hi_pc_plus4),
        .phase        (hi_phase),
        .pc_clk_out   (hi_pc_clk_out),
        .pc_we        (hi_pc_we)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [67:0] act,
                       input logic [67:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_main(input string name, input logic [1:0] ph,
                            input logic [31:0] pc, input logic ce,
                            input logic we);
        chk(name, {phase, pc_clk_out, pc_we, pc_out, pc_plus4},
            {ph, ce, we, pc, pc + 32'd4});
    endtask

    task automatic chk_hi(input string name, input logic [31:0] pc);
        chk(name, {4'h0, hi_pc_out, hi_pc_plus4},
            {4'h0, pc, pc + 32'd4});
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_in(input logic s, input logic br,
                          input logic [15:0] off, input logic jmp,
                          input logic [25:0] tgt);
        stall         = s;
        branch_taken  = br;
        branch_offset = off;
        jump          = jmp;
        jump_target   = tgt;
    endtask

    // One instruction cycle: phases 0-2 carry junk redirects and a
    // phase-1 stall, phase 3 carries the real redirect.
    task automatic add_ic(input logic [31:0] pc, input logic br,
                          input logic [15:0] off, input logic jmp,
                          input logic [25:0] tgt, input int nstall);
        vec_t v;
        for (int p = 0; p < 3; p++) begin
            v.stall = (p == 1);
            v.br    = 1'b1;
            v.off   = 16'h7fff;
            v.jmp   = (p == 0);
            v.tgt   = 26'h3ff_ffff;
            v.ph    = 2'(p);
            v.pc    = pc;
            v.ce    = (p < 2);
            v.we    = 1'b0;
            vq.push_back(v);
        end
        for (int s = 0; s <= nstall; s++) begin
            v.stall = (s < nstall);
            v.br    = br;
            v.off   = off;
            v.jmp   = jmp;
            v.tgt   = tgt;
            v.ph    = 2'd3;
            v.pc    = pc;
            v.ce    = 1'b0;
            v.we    = (s == nstall);
            vq.push_back(v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);

        add_ic(32'h0000_0000, 0, 16'h0000, 0, 26'h0,  0);
        add_ic(32'h0000_0004, 0, 16'h0000, 0, 26'h0,  0);
        add_ic(32'h0000_0008, 0, 16'h0000, 0, 26'h0,  0);
        add_ic(32'h0000_000C, 0, 16'h0000, 1, 26'h40, 0);
        add_ic(32'h0000_0100, 1, 16'hFFFE, 0, 26'h0,  0);
        add_ic(32'h0000_00FC, 0, 16'h0000, 1, 26'h40, 0);
        add_ic(32'h0000_0100, 1, 16'h0003, 0, 26'h0,  0);
        add_ic(32'h0000_0110, 0, 16'h0000, 0, 26'h0,  3);
        add_ic(32'h0000_0114, 1, 16'hFFBA, 0, 26'h0,  0);
        add_ic(32'h0000_0000, 1, 16'hFFFE, 0, 26'h0,  0);
        add_ic(32'hFFFF_FFFC, 0, 16'h0000, 0, 26'h0,  0);
        add_ic(32'h0000_0000, 1, 16'h0003, 1, 26'h10, 0);

        step();
        step();
        chk_main("reset_hold", 2'd0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            set_in(vq[i].stall, vq[i].br, vq[i].off,
                   vq[i].jmp, vq[i].tgt);
            #1;
            chk_main($sformatf("vec%0d", i), vq[i].ph, vq[i].pc,
                     vq[i].ce, vq[i].we);
            step();
        end

        set_in(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        chk_main("after_jump", 2'd0, 32'h40, 1'b1, 1'b0);
        step();
        step();
        chk_main("pre_reset_ph2", 2'd2, 32'h40, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_main("async_reset", 2'd0, 32'h0, 1'b1, 1'b0);
        chk_hi("hi_async_reset", 32'h4000_0000);
        step();
        step();
        chk_main("reset_held", 2'd0, 32'h0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b1;
        step();
        chk_main("rel_ph1", 2'd1, 32'h0, 1'b1, 1'b0);
        step();
        chk_main("rel_ph2", 2'd2, 32'h0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b1, 16'h0003, 1'b1, 26'h10);
        #1;
        chk_main("rel_ph3", 2'd3, 32'h0, 1'b0, 1'b1);
        step();
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        chk_main("rel_ph0_jump", 2'd0, 32'h40, 1'b1, 1'b0);
        chk_hi("hi_jump_prio", 32'h4000_0040);

        step();
        step();
        step();
        set_in(1'b1, 1'b1, 16'h0010, 1'b1, 26'h20);
        step();
        step();
        chk_main("stalled_ph3", 2'd3, 32'h40, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_main("reset_in_stall", 2'd0, 32'h0, 1'b1, 1'b0);
        chk_hi("hi_reset_in_stall", 32'h4000_0000);
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        step();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
